// File: rtl/lcd_bus_receiver.sv
// Responder model of an HD44780/KS0066-style 8-bit LCD bus: decodes writes into
// a 2x16 DDRAM image, address counter, display-control flags and busy/error status.
module lcd_bus_receiver #(
  parameter int BUSY_CYCLES     = 10,
  parameter int CLR_BUSY_CYCLES = 320
) (
  input  logic         mclk,
  input  logic         rst,
  input  logic [7:0]   DB,
  input  logic         RS,
  input  logic         E,
  input  logic         RW,
  output logic [127:0] LineA,
  output logic [127:0] LineB,
  output logic [6:0]   addr_cnt,
  output logic         disp_on,
  output logic         cursor_on,
  output logic         blink_on,
  output logic         busy,
  output logic         wr_strobe,
  output logic         timing_err,
  output logic         proto_err
);

  localparam int           CW    = 16;
  localparam logic [127:0] BLANK = {16{8'h20}};

  logic [1:0]    e_sync_q;
  logic          e_prev_q;
  logic [7:0]    db_q;
  logic          rs_q, rw_q;
  logic [127:0]  line_a_q, line_a_d, line_b_q, line_b_d;
  logic [6:0]    ac_q, ac_d;
  logic          id_q, id_d, sh_q, sh_d;
  logic          disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic          cg_mode_q, cg_mode_d;
  logic [5:0]    cg_addr_q, cg_addr_d;
  logic [CW-1:0] busy_cnt_q, busy_cnt_d;
  logic          busy_q, busy_d, wr_strobe_q, wr_strobe_d;
  logic          timing_err_q, timing_err_d, proto_err_q, proto_err_d;
  logic          fall_s, load_s, long_s;

  // The DDRAM address space is two 40-byte banks; stepping skips the holes.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (ac == 7'h27)      r = 7'h40;
      else if (ac == 7'h67) r = 7'h00;
      else                  r = ac + 7'd1;
    end else begin
      if (ac == 7'h00)      r = 7'h67;
      else if (ac == 7'h40) r = 7'h27;
      else                  r = ac - 7'd1;
    end
    return r;
  endfunction

  function automatic logic [6:0] ac_clamp(input logic [6:0] a);
    logic [6:0] r;
    if (a[5:0] >= 6'h28) r = {a[6], 6'h00};
    else                 r = a;
    return r;
  endfunction

  assign fall_s = e_prev_q & ~e_sync_q[1];

  // Next-state decode of the transfer completed by the falling edge of E.
  always_comb begin
    line_a_d     = line_a_q;
    line_b_d     = line_b_q;
    ac_d         = ac_q;
    id_d         = id_q;
    sh_d         = sh_q;
    disp_d       = disp_q;
    cur_d        = cur_q;
    blink_d      = blink_q;
    cg_mode_d    = cg_mode_q;
    cg_addr_d    = cg_addr_q;
    timing_err_d = timing_err_q;
    proto_err_d  = proto_err_q;
    wr_strobe_d  = 1'b0;
    load_s       = 1'b0;
    long_s       = 1'b0;

    if (fall_s) begin
      if (rw_q) begin
        proto_err_d = 1'b1;
      end else begin
        wr_strobe_d = 1'b1;
        load_s      = 1'b1;
        if (busy_q) timing_err_d = 1'b1;
        else        timing_err_d = timing_err_q;
        if (!rs_q) begin
          casez (db_q)
            8'b1???????: begin
              ac_d      = ac_clamp(db_q[6:0]);
              cg_mode_d = 1'b0;
            end
            8'b01??????: begin
              cg_mode_d = 1'b1;
              cg_addr_d = db_q[5:0];
            end
            8'b001?????: begin
              if (!db_q[4]) proto_err_d = 1'b1;
              else          proto_err_d = proto_err_q;
            end
            8'b0001????: begin
              if (!db_q[3]) ac_d = ac_step(ac_q, db_q[2]);
              else          ac_d = ac_q;
            end
            8'b00001???: begin
              disp_d  = db_q[2];
              cur_d   = db_q[1];
              blink_d = db_q[0];
            end
            8'b000001??: begin
              id_d = db_q[1];
              sh_d = db_q[0];
            end
            8'b0000001?: begin
              ac_d      = 7'h00;
              cg_mode_d = 1'b0;
              long_s    = 1'b1;
            end
            8'b00000001: begin
              line_a_d  = BLANK;
              line_b_d  = BLANK;
              ac_d      = 7'h00;
              id_d      = 1'b1;
              cg_mode_d = 1'b0;
              long_s    = 1'b1;
            end
            default: begin
              ac_d = ac_q;
            end
          endcase
        end else if (cg_mode_q) begin
          if (id_q) cg_addr_d = cg_addr_q + 6'd1;
          else      cg_addr_d = cg_addr_q - 6'd1;
        end else begin
          if (ac_q[5:4] == 2'b00) begin
            if (ac_q[6]) line_b_d[{ac_q[3:0], 3'b000} +: 8] = db_q;
            else         line_a_d[{ac_q[3:0], 3'b000} +: 8] = db_q;
          end else begin
            line_a_d = line_a_q;
          end
          ac_d = ac_step(ac_q, id_q);
        end
      end
    end else begin
      wr_strobe_d = 1'b0;
    end

    if (load_s) begin
      busy_cnt_d = long_s ? CW'(CLR_BUSY_CYCLES) : CW'(BUSY_CYCLES);
      busy_d     = 1'b1;
    end else begin
      busy_cnt_d = (busy_cnt_q != {CW{1'b0}}) ? busy_cnt_q - CW'(1) : {CW{1'b0}};
      busy_d     = (busy_cnt_q > CW'(1));
    end
  end

  // E synchronizer, bus capture and architectural state registers.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      e_sync_q     <= 2'b00;
      e_prev_q     <= 1'b0;
      db_q         <= 8'h00;
      rs_q         <= 1'b0;
      rw_q         <= 1'b0;
      line_a_q     <= BLANK;
      line_b_q     <= BLANK;
      ac_q         <= 7'h00;
      id_q         <= 1'b1;
      sh_q         <= 1'b0;
      disp_q       <= 1'b0;
      cur_q        <= 1'b0;
      blink_q      <= 1'b0;
      cg_mode_q    <= 1'b0;
      cg_addr_q    <= 6'h00;
      busy_cnt_q   <= {CW{1'b0}};
      busy_q       <= 1'b0;
      wr_strobe_q  <= 1'b0;
      timing_err_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      e_sync_q <= {e_sync_q[0], E};
      e_prev_q <= e_sync_q[1];
      if (e_sync_q[1]) begin
        db_q <= DB;
        rs_q <= RS;
        rw_q <= RW;
      end
      line_a_q     <= line_a_d;
      line_b_q     <= line_b_d;
      ac_q         <= ac_d;
      id_q         <= id_d;
      sh_q         <= sh_d;
      disp_q       <= disp_d;
      cur_q        <= cur_d;
      blink_q      <= blink_d;
      cg_mode_q    <= cg_mode_d;
      cg_addr_q    <= cg_addr_d;
      busy_cnt_q   <= busy_cnt_d;
      busy_q       <= busy_d;
      wr_strobe_q  <= wr_strobe_d;
      timing_err_q <= timing_err_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign LineA      = line_a_q;
  assign LineB      = line_b_q;
  assign addr_cnt   = ac_q;
  assign disp_on    = disp_q;
  assign cursor_on  = cur_q;
  assign blink_on   = blink_q;
  assign busy       = busy_q;
  assign wr_strobe  = wr_strobe_q;
  assign timing_err = timing_err_q;
  assign proto_err  = proto_err_q;

endmodule

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Responder side of the KS0066/HD44780-style 8-bit parallel bus that the display controller drives (DB, RS, E, RW).
- Decodes instruction and data writes, and maintains a 2x16 DDRAM image, address counter and display-control flags.
- Presents the visible screen as two 128-bit line vectors in the same packing the display side builds (column 0 at bits [7:0]).
- Used as an on-chip loopback checker and as a bench model of the panel.

Parameters:
- BUSY_CYCLES, 10, mclk cycles busy stays high after any write other than clear/home.
- CLR_BUSY_CYCLES, 320, mclk cycles busy stays high after clear display or return home.

Ports:
- mclk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- DB  in  8  LCD data bus.
- RS  in  1  register select: 0 = instruction, 1 = data.
- E  in  1  enable strobe; a transfer completes on its falling edge.
- RW  in  1  1 = read request (unsupported), 0 = write.
- LineA  out  128  visible row 0; column c at LineA[8c+:8].
- LineB  out  128  visible row 1; same packing as LineA.
- addr_cnt  out  7  DDRAM address counter (AC).
- disp_on, cursor_on, blink_on  out  1 each  display-control flags D, C, B.
- busy  out  1  busy flag.
- wr_strobe  out  1  one-cycle pulse when a write is applied.
- timing_err  out  1  sticky: a write arrived while busy was high.
- proto_err  out  1  sticky: read attempt, or function set with DL=0.

Behaviour:
- Async-low reset, all outputs:
  - LineA and LineB = {16{8'h20}}; AC=0.
  - Entry mode I/D=1, S=0; D=C=B=0; cg_mode=0; cg_addr=0.
  - busy=0, wr_strobe=0, timing_err=0, proto_err=0.
  - Reset mid-transfer discards the transfer.
- Input capture:
  - E passes through a 2-flop synchronizer.
  - DB/RS/RW are registered every cycle that synced E=1.
  - Falling edge = synced E 1→0. The write is applied on the next mclk edge; wr_strobe and all state updates are visible 1 cycle after edge detection (3 mclk after the E pin falls).
  - E high for <2 mclk is not guaranteed to be seen.
- RW=1 at the falling edge: no state change, no wr_strobe, proto_err set.
- Write while busy=1: processed normally, timing_err set, and the busy counter reloads.
- Instruction decode (RS=0), by highest set bit of DB:
  - 0x01 clear: all 32 chars = 8'h20, AC=0, I/D=1, cg_mode=0; busy for CLR_BUSY_CYCLES.
  - 0x02/0x03 home: AC=0, cg_mode=0; busy for CLR_BUSY_CYCLES.
  - 0x04–0x07 entry mode: I/D=DB[1], S=DB[0]. S is stored only; display shift is not rendered.
  - 0x08–0x0F display control: D=DB[2], C=DB[1], B=DB[0].
  - 0x10–0x1F shift: if DB[3]=0, AC moves +1 when DB[2]=1 and −1 otherwise, using the wrap rules below. If DB[3]=1, no state change.
  - 0x20–0x3F function set: DL=DB[4]=0 sets proto_err; N/F are ignored.
  - 0x40–0x7F CGRAM address: cg_mode=1, cg_addr=DB[5:0].
  - 0x80–0xFF DDRAM address: AC=DB[6:0], cg_mode=0. Values 0x28–0x3F and 0x68–0x7F are clamped: 0x28–0x3F→0x00, 0x68–0x7F→0x40.
  - 0x00: no-op, but still busy for BUSY_CYCLES.
- Data write (RS=1):
  - If cg_mode=1: pattern byte is discarded, cg_addr increments or decrements per I/D mod 64, AC is untouched.
  - Otherwise: the char is stored if AC is in 0x00–0x0F (LineA column AC) or 0x40–0x4F (LineB column AC−0x40). Writes to 0x10–0x27 and 0x50–0x67 are accepted but not visible. AC then steps per I/D.
- AC wrap:
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
- Busy:
  - Counter loads on every applied write; busy=1 from the wr_strobe cycle for exactly N cycles.
  - busy never gates decoding.

Test Plan:
- Reset, then write 0x38, 0x0C, 0x06, 0x80, data 'S','e','t' → LineA[23:0]=24'h746553, disp_on=1, cursor_on=0, AC=0x03, other chars 0x20, flags clear.
- Write 0xC0, then 16 data bytes 0x30..0x3F → LineB[127:120]=0x3F, LineB[7:0]=0x30. AC: 0x4F after the 15th byte, 0x50 after the 16th.
- Set AC=0x27 and write 1 byte → AC=0x40. Set AC=0x67 and write 1 byte → AC=0x00. With I/D=0 (0x04) at AC=0x00, write 1 byte → AC=0x67, and LineA col 0 holds the byte.
- After screen fill, write 0x01 → all chars 0x20, AC=0, busy high exactly 320 cycles. A second write at cycle 100 sets timing_err and reloads busy.
- Write 0x40 then 8 data bytes → LineA/LineB unchanged, AC unchanged. Write 0x85 → cg_mode cleared, next data lands in LineA col 5.
- E pulse with RW=1 → no wr_strobe, proto_err=1. Write 0x28 → proto_err stays 1. Assert rst low mid-E pulse → all outputs at reset values immediately, and the pending transfer is not applied.
